// File: rtl/fifo_uart_tx.sv
// UART transmitter draining a first-word-fall-through FIFO; tx falls the cycle after the pop and tx_en only gates new frames.
// Define FIFO_UART_TX_PARITY_EN to insert an even parity bit between the last data bit and the stop bit(s).
module fifo_uart_tx #(
  parameter int dat_width    = 8,
  parameter int clks_per_bit = 434,
  parameter int stop_bits    = 1
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_tx_en,
  input  logic                 i_fifo_empty,
  input  logic [dat_width-1:0] i_fifo_data,
  output logic                 o_fifo_rd,
  output logic                 o_tx,
  output logic                 o_busy
);

  localparam int                BIDX_W    = (dat_width > 1) ? $clog2(dat_width) : 1;
  localparam logic [15:0]       BIT_LAST  = 16'(clks_per_bit - 1);
  localparam logic [BIDX_W-1:0] LAST_DAT  = BIDX_W'(dat_width - 1);
  localparam logic [BIDX_W-1:0] LAST_STOP = BIDX_W'(stop_bits - 1);

`ifdef FIFO_UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_STOP   = 3'd3,
    S_PARITY = 3'd4
  } state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;
`endif

  state_t               r_state;
  state_t               w_state_nxt;
  logic [15:0]          r_bcnt;
  logic [BIDX_W-1:0]    r_bidx;
  logic [dat_width-1:0] r_shreg;
  logic [dat_width-1:0] w_shreg_nxt;
  logic                 r_tx;
  logic                 w_tx_nxt;
  logic                 w_pop;
  logic                 w_bit_end;
`ifdef FIFO_UART_TX_PARITY_EN
  logic                 r_par;
  logic                 w_par_nxt;
`endif

  // Pop is gated by reset so the FIFO never loses a word while we are held in reset.
  assign w_pop     = i_reset & i_tx_en & ~i_fifo_empty & (r_state == S_IDLE);
  assign w_bit_end = (r_bcnt == BIT_LAST);
  assign o_tx      = r_tx;

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_pop) w_state_nxt = S_START;
      S_START: if (w_bit_end) w_state_nxt = S_DATA;
      S_DATA: begin
        if (w_bit_end && (r_bidx == LAST_DAT)) begin
`ifdef FIFO_UART_TX_PARITY_EN
          w_state_nxt = S_PARITY;
`else
          w_state_nxt = S_STOP;
`endif
        end
      end
`ifdef FIFO_UART_TX_PARITY_EN
      S_PARITY: if (w_bit_end) w_state_nxt = S_STOP;
`endif
      S_STOP:  if (w_bit_end && (r_bidx == LAST_STOP)) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // tx is registered from the next-state view so the line changes on the same edge as the state.
  always_comb begin
    o_fifo_rd   = w_pop;
    o_busy      = i_reset & ((r_state != S_IDLE) | w_pop);
    w_shreg_nxt = r_shreg;
    if (w_pop) begin
      w_shreg_nxt = i_fifo_data;
    end else if ((r_state == S_DATA) && w_bit_end) begin
      w_shreg_nxt = r_shreg >> 1;
    end
`ifdef FIFO_UART_TX_PARITY_EN
    w_par_nxt = w_pop ? ^i_fifo_data : r_par;
`endif
    case (w_state_nxt)
      S_START:  w_tx_nxt = 1'b0;
      S_DATA:   w_tx_nxt = w_shreg_nxt[0];
`ifdef FIFO_UART_TX_PARITY_EN
      S_PARITY: w_tx_nxt = w_par_nxt;
`endif
      default:  w_tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_bcnt  <= 16'd0;
      r_bidx  <= '0;
      r_shreg <= '0;
      r_tx    <= 1'b1;
`ifdef FIFO_UART_TX_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      r_shreg <= w_shreg_nxt;
      r_tx    <= w_tx_nxt;
`ifdef FIFO_UART_TX_PARITY_EN
      r_par   <= w_par_nxt;
`endif
      if ((r_state == S_IDLE) || w_bit_end) begin
        r_bcnt <= 16'd0;
      end else begin
        r_bcnt <= r_bcnt + 16'd1;
      end
      // bidx counts data bits, then is reused to count stop bits.
      if (r_state == S_IDLE) begin
        r_bidx <= '0;
      end else if (w_bit_end && ((r_state == S_DATA) || (r_state == S_STOP))) begin
        r_bidx <= (w_state_nxt != r_state) ? '0 : r_bidx + BIDX_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: FIFO model feeds the DUT, a monitor logs per-cycle line state, tasks compare against a frame model.
module tb_fifo_uart_tx;
  localparam int DW  = 8;
  localparam int CPB = 4;
  localparam int SB  = 1;
`ifdef FIFO_UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int FRAME = (1 + DW + P + SB) * CPB;
  localparam int HMAX  = 4096;

  logic          clk        = 1'b0;
  logic          rst_n      = 1'b0;
  logic          tx_en      = 1'b0;
  logic          fifo_empty = 1'b1;
  logic [DW-1:0] fifo_data  = '0;
  logic          fifo_rd;
  logic          tx;
  logic          busy;

  fifo_uart_tx #(.dat_width(DW), .clks_per_bit(CPB), .stop_bits(SB)) dut (
    .i_clk(clk), .i_reset(rst_n), .i_tx_en(tx_en), .i_fifo_empty(fifo_empty),
    .i_fifo_data(fifo_data), .o_fifo_rd(fifo_rd), .o_tx(tx), .o_busy(busy)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [0:63];
  int            wr_ptr = 0;
  int            rd_ptr = 0;
  int            cyc    = 0;
  logic          rd_n   = 1'b0;
  logic          tx_h   [0:HMAX-1];
  logic          busy_h [0:HMAX-1];
  logic          rd_h   [0:HMAX-1];
  logic          emp_h  [0:HMAX-1];
  int            pop_cyc  [0:63];
  logic [DW-1:0] pop_word [0:63];
  int            npop  = 0;
  int            n_cmp = 0;
  int            n_err = 0;

  // FWFT FIFO model: a pop seen during a cycle takes effect just after the closing edge.
  always @(posedge clk) begin
    #1;
    if (rd_n) rd_ptr = rd_ptr + 1;
    cyc = cyc + 1;
    fifo_empty = (rd_ptr == wr_ptr);
    fifo_data  = fifo_empty ? '0 : mem[rd_ptr % 64];
  end

  always @(negedge clk) begin
    rd_n = fifo_rd;
    if (cyc < HMAX) begin
      tx_h[cyc] = tx; busy_h[cyc] = busy; rd_h[cyc] = fifo_rd; emp_h[cyc] = fifo_empty;
    end
    if (fifo_rd === 1'b1 && npop < 64) begin
      pop_cyc[npop] = cyc; pop_word[npop] = mem[rd_ptr % 64]; npop = npop + 1;
    end
  end

  task automatic tick;
    @(posedge clk); #2;
  endtask

  task automatic push(input logic [DW-1:0] v);
    mem[wr_ptr % 64] = v; wr_ptr = wr_ptr + 1;
  endtask

  task automatic wait_pop(input int n0, input int budget, output bit ok);
    int b = budget;
    while (npop <= n0 && b > 0) begin tick; b--; end
    ok = (npop > n0);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick;
  endtask

  // Expected line level k cycles after the pop cycle + 1: start, data LSB first, parity, stop.
  function automatic logic exp_tx(input logic [DW-1:0] w, input int k);
    int b;
    b = k / CPB;
    if (b == 0) return 1'b0;
    if (b <= DW) return w[b-1];
    if (P == 1 && b == DW + 1) return ^w;
    return 1'b1;
  endfunction

  task automatic test_reset;
    rst_n = 1'b0; tx_en = 1'b1; push(8'hA5);
    tick;
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (tx !== 1'b1) begin n_err++; $display("FAIL reset_tx cyc%0d: got %b want 1", i, tx); end
      n_cmp++; if (fifo_rd !== 1'b0) begin n_err++; $display("FAIL reset_rd cyc%0d: got %b want 0", i, fifo_rd); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy cyc%0d: got %b want 0", i, busy); end
      tick;
    end
  endtask

  task automatic test_single_byte;
    int n0, p, bad, bcount; bit ok;
    n0 = npop; rst_n = 1'b1;
    wait_pop(n0, 10, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL single_pop_timeout: got %0d pops want 1", npop - n0); end
    if (ok) begin
      p = pop_cyc[n0];
      wait_until(p + FRAME + 8);
      n_cmp++; if (npop - n0 != 1) begin n_err++; $display("FAIL single_pop_count: got %0d want 1", npop - n0); end
      n_cmp++; if (pop_word[n0] !== 8'hA5) begin n_err++; $display("FAIL single_word: got %h want a5", pop_word[n0]); end
      n_cmp++; if (rd_h[p+1] !== 1'b0) begin n_err++; $display("FAIL single_rd_width: got %b want 0", rd_h[p+1]); end
      n_cmp++; if (tx_h[p] !== 1'b1) begin n_err++; $display("FAIL single_tx_popcyc: got %b want 1", tx_h[p]); end
      bad = -1;
      for (int k = 0; k < FRAME; k++) if (bad < 0 && tx_h[p+1+k] !== exp_tx(8'hA5, k)) bad = k;
      n_cmp++; if (bad >= 0) begin n_err++; $display("FAIL single_frame at %0d: got %b want %b", bad, tx_h[p+1+bad], exp_tx(8'hA5, bad)); end
      bcount = 0;
      for (int c = p - 2; c < p + FRAME + 6; c++) if (busy_h[c] === 1'b1) bcount++;
      n_cmp++; if (bcount != FRAME + 1) begin n_err++; $display("FAIL single_busy_len: got %0d want %0d", bcount, FRAME + 1); end
      n_cmp++; if (busy_h[p+FRAME+1] !== 1'b0) begin n_err++; $display("FAIL single_busy_end: got %b want 0", busy_h[p+FRAME+1]); end
    end
  endtask

  task automatic test_back_to_back;
    int n0, p0, p1, bad, ones; bit ok0, ok1;
    n0 = npop; push(8'h00); push(8'hFF);
    wait_pop(n0, 10, ok0);
    wait_pop(n0 + 1, FRAME + 10, ok1);
    n_cmp++; if (!(ok0 && ok1)) begin n_err++; $display("FAIL b2b_timeout: got %0d pops want 2", npop - n0); end
    if (ok0 && ok1) begin
      p0 = pop_cyc[n0]; p1 = pop_cyc[n0+1];
      wait_until(p1 + FRAME + 8);
      n_cmp++; if (p1 - p0 != FRAME + 1) begin n_err++; $display("FAIL b2b_period: got %0d want %0d", p1 - p0, FRAME + 1); end
      bad = -1;
      for (int k = 0; k < FRAME; k++) if (bad < 0 && tx_h[p0+1+k] !== exp_tx(8'h00, k)) bad = k;
      n_cmp++; if (bad >= 0) begin n_err++; $display("FAIL b2b_frame0 at %0d: got %b want %b", bad, tx_h[p0+1+bad], exp_tx(8'h00, bad)); end
      bad = -1;
      for (int k = 0; k < FRAME; k++) if (bad < 0 && tx_h[p1+1+k] !== exp_tx(8'hFF, k)) bad = k;
      n_cmp++; if (bad >= 0) begin n_err++; $display("FAIL b2b_frame1 at %0d: got %b want %b", bad, tx_h[p1+1+bad], exp_tx(8'hFF, bad)); end
      ones = 0;
      for (int k = CPB; k < (DW + 1) * CPB; k++) if (tx_h[p1+1+k] === 1'b1) ones++;
      n_cmp++; if (ones != DW * CPB) begin n_err++; $display("FAIL b2b_data_ones: got %0d want %0d", ones, DW * CPB); end
    end
  endtask

  task automatic test_flow_gating;
    int n0, p, p2, c, bad; bit ok, ok2;
    n0 = npop; push(8'h3C); push(8'h55);
    wait_pop(n0, 10, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL gate_pop_timeout: got %0d pops want 1", npop - n0); end
    if (ok) begin
      p = pop_cyc[n0];
      wait_until(p + 1 + 3 * CPB + 1);
      tx_en = 1'b0;
      wait_until(p + FRAME + 60);
      n_cmp++; if (npop - n0 != 1) begin n_err++; $display("FAIL gate_held: got %0d pops want 1", npop - n0); end
      bad = -1;
      for (int k = 0; k < FRAME; k++) if (bad < 0 && tx_h[p+1+k] !== exp_tx(8'h3C, k)) bad = k;
      n_cmp++; if (bad >= 0) begin n_err++; $display("FAIL gate_frame at %0d: got %b want %b", bad, tx_h[p+1+bad], exp_tx(8'h3C, bad)); end
      n_cmp++; if (busy_h[p+FRAME+1] !== 1'b0) begin n_err++; $display("FAIL gate_busy_idle: got %b want 0", busy_h[p+FRAME+1]); end
      c = cyc; tx_en = 1'b1;
      wait_pop(n0 + 1, 10, ok2);
      n_cmp++; if (!ok2) begin n_err++; $display("FAIL gate_resume_timeout: got %0d pops want 2", npop - n0); end
      if (ok2) begin
        p2 = pop_cyc[n0+1];
        wait_until(p2 + FRAME + 8);
        n_cmp++; if (p2 != c) begin n_err++; $display("FAIL gate_resume_cyc: got %0d want %0d", p2, c); end
        n_cmp++; if (pop_word[n0+1] !== 8'h55) begin n_err++; $display("FAIL gate_resume_word: got %h want 55", pop_word[n0+1]); end
        bad = -1;
        for (int k = 0; k < FRAME; k++) if (bad < 0 && tx_h[p2+1+k] !== exp_tx(8'h55, k)) bad = k;
        n_cmp++; if (bad >= 0) begin n_err++; $display("FAIL gate_frame2 at %0d: got %b want %b", bad, tx_h[p2+1+bad], exp_tx(8'h55, bad)); end
      end
    end
  endtask

  task automatic test_reset_midframe;
    int n0, p, r, p2, bad; bit ok, ok2;
    n0 = npop; push(8'h96); push(8'h69);
    wait_pop(n0, 10, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL rmid_pop_timeout: got %0d pops want 1", npop - n0); end
    if (ok) begin
      p = pop_cyc[n0]; r = p + 1 + 4 * CPB + 1;
      wait_until(r);
      rst_n = 1'b0; tick; tick; tick; rst_n = 1'b1;
      wait_pop(n0 + 1, 10, ok2);
      n_cmp++; if (tx_h[r-1] !== exp_tx(8'h96, r - 1 - (p + 1))) begin n_err++; $display("FAIL rmid_pre_tx: got %b want %b", tx_h[r-1], exp_tx(8'h96, r - 1 - (p + 1))); end
      n_cmp++; if (tx_h[r+1] !== 1'b1) begin n_err++; $display("FAIL rmid_tx_high: got %b want 1", tx_h[r+1]); end
      for (int c = r; c < r + 3; c++) begin
        n_cmp++; if (busy_h[c] !== 1'b0 || rd_h[c] !== 1'b0) begin n_err++; $display("FAIL rmid_quiet cyc%0d: got busy %b rd %b want 0 0", c, busy_h[c], rd_h[c]); end
      end
      n_cmp++; if (!ok2) begin n_err++; $display("FAIL rmid_resume_timeout: got %0d pops want 2", npop - n0); end
      if (ok2) begin
        p2 = pop_cyc[n0+1];
        wait_until(p2 + FRAME + 8);
        n_cmp++; if (p2 != r + 3) begin n_err++; $display("FAIL rmid_resume_cyc: got %0d want %0d", p2, r + 3); end
        n_cmp++; if (pop_word[n0+1] !== 8'h69) begin n_err++; $display("FAIL rmid_word: got %h want 69", pop_word[n0+1]); end
        bad = -1;
        for (int k = 0; k < FRAME; k++) if (bad < 0 && tx_h[p2+1+k] !== exp_tx(8'h69, k)) bad = k;
        n_cmp++; if (bad >= 0) begin n_err++; $display("FAIL rmid_frame at %0d: got %b want %b", bad, tx_h[p2+1+bad], exp_tx(8'h69, bad)); end
      end
    end
  endtask

  task automatic test_random;
    int n0, s, e, c, p, bad; bit ok;
    logic [DW-1:0] words [0:5];
    n0 = npop; s = cyc;
    for (int i = 0; i < 6; i++) begin
      words[i] = DW'($urandom);
      push(words[i]);
      repeat ($urandom_range(0, 60)) tick;
    end
    wait_pop(n0 + 5, 6 * (FRAME + 1) + 100, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL rand_timeout: got %0d pops want 6", npop - n0); end
    if (ok) begin
      wait_until(pop_cyc[n0+5] + FRAME + 8);
      e = s;
      for (int i = 0; i < 6; i++) begin
        p = pop_cyc[n0+i];
        c = e;
        while (c < cyc - 1 && emp_h[c] === 1'b1) c++;
        n_cmp++; if (p != c) begin n_err++; $display("FAIL rand_pop_cyc[%0d]: got %0d want %0d", i, p, c); end
        bad = -1;
        for (int k = 0; k < FRAME; k++) if (bad < 0 && tx_h[p+1+k] !== exp_tx(words[i], k)) bad = k;
        n_cmp++; if (bad >= 0) begin n_err++; $display("FAIL rand_frame[%0d] %h at %0d: got %b want %b", i, words[i], bad, tx_h[p+1+bad], exp_tx(words[i], bad)); end
        e = p + FRAME + 1;
      end
    end
  endtask

`ifdef FIFO_UART_TX_PARITY_EN
  task automatic test_parity;
    int n0, p0, p1, pb; bit ok0, ok1;
    n0 = npop; push(8'h07); push(8'h03);
    wait_pop(n0, 10, ok0);
    wait_pop(n0 + 1, FRAME + 10, ok1);
    n_cmp++; if (!(ok0 && ok1)) begin n_err++; $display("FAIL par_timeout: got %0d pops want 2", npop - n0); end
    if (ok0 && ok1) begin
      p0 = pop_cyc[n0]; p1 = pop_cyc[n0+1];
      wait_until(p1 + FRAME + 8);
      pb = (DW + 1) * CPB + 1;
      n_cmp++; if (p1 - p0 != 45) begin n_err++; $display("FAIL par_period: got %0d want 45", p1 - p0); end
      n_cmp++; if (tx_h[p0+1+pb] !== 1'b1) begin n_err++; $display("FAIL par_bit_07: got %b want 1", tx_h[p0+1+pb]); end
      n_cmp++; if (tx_h[p1+1+pb] !== 1'b0) begin n_err++; $display("FAIL par_bit_03: got %b want 0", tx_h[p1+1+pb]); end
      n_cmp++; if (busy_h[p1+44] !== 1'b1 || busy_h[p1+45] !== 1'b0) begin n_err++; $display("FAIL par_busy_span: got %b%b want 10", busy_h[p1+44], busy_h[p1+45]); end
    end
  endtask
`endif

  task automatic test_pop_rules;
    int bad_empty;
    bad_empty = 0;
    for (int c = 1; c < cyc - 1 && c < HMAX; c++) if (rd_h[c] === 1'b1 && emp_h[c] === 1'b1) bad_empty++;
    n_cmp++; if (bad_empty != 0) begin n_err++; $display("FAIL pop_while_empty: got %0d want 0", bad_empty); end
    n_cmp++; if (npop != wr_ptr) begin n_err++; $display("FAIL total_pops: got %0d want %0d", npop, wr_ptr); end
  endtask

  initial begin
    test_reset;
    test_single_byte;
    test_back_to_back;
    test_flow_gating;
    test_reset_midframe;
    test_random;
`ifdef FIFO_UART_TX_PARITY_EN
    test_parity;
`endif
    test_pop_rules;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/fifo_uart_tx.md
# fifo_uart_tx

Serial transmitter on the read side of the cyclic FIFO. It pops one word at a time from a first-word-fall-through FIFO and shifts it out as an asynchronous UART frame: start bit, data LSB first, optional parity, stop bit(s). It sits between a block's output FIFO and the board TX pin, so any block that fills a FIFO gets a serial link without its own timing logic.

## Interface
- `dat_width`, default 8: data bits per frame; equals the FIFO `dat_width`.
- `clks_per_bit`, default 434: `clk` cycles per bit (50 MHz / 115200). Legal range 2..65535.
- `stop_bits`, default 1: number of stop bits, 1 or 2.
- `clk`  in  1: single clock; all logic on rising edge.
- `reset`  in  1: synchronous, active-low reset (asserted when 0, sampled on `clk` rising edge).
- `tx_en`  in  1: permits starting a new frame; a frame already in progress always completes.
- `fifo_empty`  in  1: FIFO empty flag.
- `fifo_data`  in  `dat_width`: FIFO head word, valid whenever `fifo_empty`=0.
- `fifo_rd`  out  1: pop strobe to FIFO, one-cycle pulse.
- `tx`  out  1: serial line, idle high.
- `busy`  out  1: high from the pop cycle through the last stop-bit cycle.

## Operation
- FSM states: IDLE, START, DATA, PARITY (only with macro), STOP.
- Internal state: 16-bit baud counter `bcnt`, bit index `bidx` (clog2(`dat_width`) bits), shift register `shreg` (`dat_width`).
- IDLE: `tx`=1. If `tx_en`=1 and `fifo_empty`=0, the block does all of the following in the same cycle:
  - drives `fifo_rd`=1 combinationally in that cycle;
  - latches `fifo_data` into `shreg`;
  - clears `bcnt`;
  - moves to START.
- START: `tx`=0 for `clks_per_bit` cycles.
- DATA: `tx`=`shreg[0]`. On each bit end, `shreg` shifts right and `bidx` increments. After bit `dat_width`-1 the FSM moves to PARITY or STOP.
- PARITY: `tx` = XOR of the latched word, giving even parity. Held for `clks_per_bit` cycles.
- STOP: `tx`=1 for `stop_bits`×`clks_per_bit` cycles, then returns to IDLE.
- Bit end: `bcnt`==`clks_per_bit`-1. At bit end `bcnt` wraps to 0; otherwise `bcnt` increments.
- `fifo_rd` is asserted only in IDLE with `fifo_empty`=0 and `tx_en`=1. It is never asserted while `fifo_empty`=1, and never more than once per frame.
- `tx_en` deasserted mid-frame: the current frame finishes; the block then stays in IDLE until `tx_en`=1.
- `fifo_empty` rising mid-frame: no effect on the current frame.

## Timing
- Reset values (one cycle after `reset` sampled low):
  - `tx`=1, `fifo_rd`=0, `busy`=0;
  - state IDLE, `bcnt`=0, `bidx`=0.
- Reset mid-frame: the frame is aborted and that word is lost. `tx` returns to 1 on the reset edge, and no pop occurs while `reset`=0.
- Latency: `tx` falls on the cycle after the `fifo_rd` pulse.
- Frame length in cycles: (1 + `dat_width` + P + `stop_bits`) × `clks_per_bit`, where P=1 with the macro and 0 without.
- Back-to-back words: one IDLE cycle separates frames. Pop period = frame length + 1 cycle.
- `busy` is high from the pop cycle through the final STOP cycle, and low in the IDLE cycle that follows.
- `tx` is driven directly from a register; it has no combinational path from any input.

## Configuration
- Macro `FIFO_UART_TX_PARITY_EN`.
- Defined: the PARITY state is compiled in. An even parity bit is sent between the last data bit and the first stop bit.
- Undefined: no PARITY state and no parity logic. DATA goes directly to STOP.

## Test plan
- Reset: hold `reset`=0 for 3 cycles with `fifo_empty`=0 and `tx_en`=1 -> `tx`=1, `fifo_rd`=0, `busy`=0 throughout.
- Single byte (`clks_per_bit`=4, no parity): present 0xA5 with `fifo_empty`=0, then raise `fifo_empty` after the pop.
  - Exactly one `fifo_rd` pulse.
  - `tx` sequence, each level held 4 cycles: 0, 1,0,1,0,0,1,0,1, 1.
  - `busy` high for 41 cycles.
- Back-to-back: FIFO holds 0x00 and 0xFF -> two `fifo_rd` pulses exactly 41 cycles apart; second frame's data bits are all 1.
- Flow gating: deassert `tx_en` during the DATA bits of 0x3C -> that frame completes; no further `fifo_rd` until `tx_en`=1, even with `fifo_empty`=0.
- Reset mid-frame: assert `reset`=0 during bit 3 -> `tx`=1 on the next edge, `busy`=0, no pop while in reset; after release the next word is sent as a full frame.
- Parity (macro defined): send 0x07 -> parity bit 1; send 0x03 -> parity bit 0; frame length 44 cycles at `clks_per_bit`=4.
